// File: rtl/frame_readout_ctrl.sv
// frame_readout_ctrl
//   Frame sequencer for one pixel array. It erases the array, exposes it, then
//   ramp-converts each row in turn and captures the row into a local buffer.
//   The buffered row is streamed out one byte per beat over valid/ready. A slow
//   sink only stretches the SHIFT phase; it never disturbs a conversion in flight.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start             frame request, honoured only while idle
//   expose_cycles     exposure length, sampled with start (0 behaves as 1)
//   data_in           pixel array output, column c at bits [c*8+7:c*8]
//   pix_ready         sink accepts the current beat
//   busy              high whenever a frame is in progress
//   p_erase/p_expose  pixel array erase and expose controls
//   p_expose_clk      toggles every exposure cycle, starting high
//   p_row_select      one-hot row under conversion
//   p_aRamp/p_dRamp   analog ramp enable and digital ramp code
//   pix_data/valid    output beat and its qualifier
//   pix_sof/pix_eol   first beat of frame / last beat of a row
//   frame_done        one-cycle pulse at the end of a frame
module frame_readout_ctrl #(
  parameter int PIXEL_ARRAY_WIDTH  = 4,
  parameter int PIXEL_ARRAY_HEIGHT = 4,
  parameter int ERASE_CYCLES       = 5,
  parameter int EXPOSE_W           = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [EXPOSE_W-1:0]            expose_cycles,
  input  logic [PIXEL_ARRAY_WIDTH*8-1:0] data_in,
  input  logic                           pix_ready,
  output logic                           busy,
  output logic                           p_erase,
  output logic                           p_expose,
  output logic                           p_expose_clk,
  output logic [PIXEL_ARRAY_HEIGHT-1:0]  p_row_select,
  output logic                           p_aRamp,
  output logic [7:0]                     p_dRamp,
  output logic [7:0]                     pix_data,
  output logic                           pix_valid,
  output logic                           pix_sof,
  output logic                           pix_eol,
  output logic                           frame_done
);

  localparam int COL_W   = (PIXEL_ARRAY_WIDTH  > 1) ? $clog2(PIXEL_ARRAY_WIDTH)  : 1;
  localparam int ROW_W   = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
  localparam int ERASE_W = $clog2(ERASE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t              state;
  logic [ERASE_W-1:0]  erase_cnt;
  logic [EXPOSE_W-1:0] exp_cnt;
  logic [EXPOSE_W-1:0] n_lat;
  logic [ROW_W-1:0]    row;
  logic [COL_W-1:0]    col;
  logic [7:0]          row_buf [PIXEL_ARRAY_WIDTH];

  logic [COL_W-1:0] col_next;
  logic [ROW_W-1:0] row_next;
  logic             last_col;
  logic             last_row;

  assign col_next = col + COL_W'(1);
  assign row_next = row + ROW_W'(1);
  assign last_col = (col == COL_W'(PIXEL_ARRAY_WIDTH - 1));
  assign last_row = (row == ROW_W'(PIXEL_ARRAY_HEIGHT - 1));

  // Single sequencer: every output is a register updated on the transition
  // into the state that owns it, so outputs line up exactly with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      erase_cnt    <= '0;
      exp_cnt      <= '0;
      n_lat        <= '0;
      row          <= '0;
      col          <= '0;
      busy         <= 1'b0;
      p_erase      <= 1'b0;
      p_expose     <= 1'b0;
      p_expose_clk <= 1'b0;
      p_row_select <= '0;
      p_aRamp      <= 1'b0;
      p_dRamp      <= '0;
      pix_data     <= '0;
      pix_valid    <= 1'b0;
      pix_sof      <= 1'b0;
      pix_eol      <= 1'b0;
      frame_done   <= 1'b0;
      for (int c = 0; c < PIXEL_ARRAY_WIDTH; c++) begin
        row_buf[c] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_ERASE;
            busy      <= 1'b1;
            p_erase   <= 1'b1;
            erase_cnt <= '0;
            row       <= '0;
            n_lat     <= (expose_cycles == '0) ? EXPOSE_W'(1) : expose_cycles;
          end
        end

        S_ERASE: begin
          if (erase_cnt == ERASE_W'(ERASE_CYCLES - 1)) begin
            state        <= S_EXPOSE;
            p_erase      <= 1'b0;
            p_expose     <= 1'b1;
            p_expose_clk <= 1'b1;
            exp_cnt      <= '0;
          end else begin
            erase_cnt <= erase_cnt + ERASE_W'(1);
          end
        end

        S_EXPOSE: begin
          if (exp_cnt == n_lat - EXPOSE_W'(1)) begin
            state        <= S_CONVERT;
            p_expose     <= 1'b0;
            p_expose_clk <= 1'b0;
            p_row_select <= PIXEL_ARRAY_HEIGHT'(1) << row;
            p_aRamp      <= 1'b1;
            p_dRamp      <= '0;
          end else begin
            exp_cnt      <= exp_cnt + EXPOSE_W'(1);
            p_expose_clk <= ~p_expose_clk;
          end
        end

        // Column 0 is presented straight from data_in because the buffer
        // entry is only being written on this same edge.
        S_CONVERT: begin
          if (p_dRamp == 8'hFF) begin
            for (int c = 0; c < PIXEL_ARRAY_WIDTH; c++) begin
              row_buf[c] <= data_in[c*8 +: 8];
            end
            state        <= S_SHIFT;
            p_row_select <= '0;
            p_aRamp      <= 1'b0;
            p_dRamp      <= '0;
            col          <= '0;
            pix_valid    <= 1'b1;
            pix_data     <= data_in[7:0];
            pix_sof      <= (row == '0);
            pix_eol      <= (PIXEL_ARRAY_WIDTH == 1);
          end else begin
            p_dRamp <= p_dRamp + 8'd1;
          end
        end

        // Beat registers only move on a transfer, which keeps the beat
        // stable for as long as the sink stalls.
        S_SHIFT: begin
          if (pix_ready) begin
            if (last_col) begin
              pix_valid <= 1'b0;
              pix_data  <= '0;
              pix_sof   <= 1'b0;
              pix_eol   <= 1'b0;
              if (last_row) begin
                state      <= S_DONE;
                frame_done <= 1'b1;
              end else begin
                state        <= S_CONVERT;
                row          <= row_next;
                p_row_select <= PIXEL_ARRAY_HEIGHT'(1) << row_next;
                p_aRamp      <= 1'b1;
                p_dRamp      <= '0;
              end
            end else begin
              col      <= col_next;
              pix_data <= row_buf[col_next];
              pix_sof  <= 1'b0;
              pix_eol  <= (col_next == COL_W'(PIXEL_ARRAY_WIDTH - 1));
            end
          end
        end

        S_DONE: begin
          state      <= S_IDLE;
          frame_done <= 1'b0;
          busy       <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
